// File: rtl/pipe_reg_skid.sv
// Pipeline-stage register with valid/ready handshake, one-entry skid buffer,
// flush of in-flight beats and a saturating stall counter.
module pipe_reg_skid #(
    parameter int DATA_W = 64,
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    input  logic              flush,
    output logic [CNT_W-1:0]  stall_count,
    output logic [1:0]        dbg_state
);

    // Handshake: a beat moves on a side only in a cycle where both valid and
    // ready are high at the posedge; valid never waits on ready, and in_ready
    // is a register that does not look at out_ready combinationally.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t            state, state_nxt;
    logic [DATA_W-1:0] main_data, skid_data;
    logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
    logic              in_ready_q;
    logic [CNT_W-1:0]  stall_q;
    logic              accept, drain;
    logic              load_main_in, load_main_skid, load_skid;

    assign out_valid   = (state != ST_EMPTY);
    assign in_ready    = in_ready_q;
    assign accept      = in_valid & in_ready_q;
    assign drain       = out_valid & out_ready;
    assign out_data    = main_data;
    assign out_ctrl    = out_valid ? main_ctrl : '0;
    assign stall_count = stall_q;
    assign dbg_state   = state;

    always_comb begin
        state_nxt      = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (accept) begin
                    state_nxt    = ST_FULL;
                    load_main_in = 1'b1;
                end
            end
            ST_FULL: begin
                if (accept && drain) begin
                    load_main_in = 1'b1;
                end else if (accept) begin
                    state_nxt = ST_SKID;
                    load_skid = 1'b1;
                end else if (drain) begin
                    state_nxt = ST_EMPTY;
                end
            end
            ST_SKID: begin
                if (drain) begin
                    state_nxt      = ST_FULL;
                    load_main_skid = 1'b1;
                end
            end
            default: state_nxt = ST_EMPTY;
        endcase
        // Flush kills every beat but leaves payload registers stale.
        if (flush) begin
            state_nxt      = ST_EMPTY;
            load_main_in   = 1'b0;
            load_main_skid = 1'b0;
            load_skid      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_EMPTY;
            in_ready_q <= 1'b0;
            main_data  <= '0;
            main_ctrl  <= '0;
            skid_data  <= '0;
            skid_ctrl  <= '0;
            stall_q    <= '0;
        end else begin
            state      <= state_nxt;
            in_ready_q <= (state_nxt != ST_SKID);
            if (load_main_in) begin
                main_data <= in_data;
                main_ctrl <= in_ctrl;
            end else if (load_main_skid) begin
                main_data <= skid_data;
                main_ctrl <= skid_ctrl;
            end
            if (load_skid) begin
                skid_data <= in_data;
                skid_ctrl <= in_ctrl;
            end
            if (out_valid && !out_ready && stall_q != CNT_MAX) begin
                stall_q <= stall_q + 1'b1;
            end
        end
    end

endmodule
